// File: rtl/pwm_capture_decoder.sv
// PWM receiver: measures high time and period on the generator's prescaler tick grid and
// decodes duty and servo codes, strobing valid_o once per completed period.
module pwm_capture_decoder #(
    parameter int unsigned DVSR_FAST = 10416,
    parameter int unsigned DVSR_SLOW = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel_i,
    input  logic       pwm_i,
    output logic [7:0] high_o,
    output logic [7:0] period_o,
    output logic [6:0] duty_o,
    output logic [3:0] servo_o,
    output logic       valid_o,
    output logic       timeout_o
);
    typedef enum logic [1:0] {StIdle, StWaitRise, StHigh, StLow} state_e;

    state_e      state_q, state_d;
    logic        sync_q, pwm_s_q, pwm_d_q;
    logic        sel_q;
    logic [31:0] q_q, q_d;
    logic [7:0]  hi_q, hi_d, per_q, per_d;
    logic [7:0]  high_q, high_d, period_q, period_d;
    logic [6:0]  duty_q, duty_d;
    logic [3:0]  servo_q, servo_d;
    logic        valid_q, valid_d, timeout_q, timeout_d;

    logic        rise, fall, tick, mode_chg, per_full;
    logic [31:0] dvsr;
    logic [7:0]  hi_inc, per_inc, per_latch;

    // Inverse of the generator mapping 5 + d*5/15; only 5..9 reach the multiply.
    function automatic logic [3:0] servo_code(input logic [7:0] h);
        logic [3:0] off;
        logic [3:0] code;
        off = h[3:0] - 4'd5;
        if (h < 8'd5) begin
            code = 4'd0;
        end else if (h >= 8'd10) begin
            code = 4'd15;
        end else begin
            code = off * 4'd3;
        end
        return code;
    endfunction

    assign rise      = pwm_s_q & ~pwm_d_q;
    assign fall      = ~pwm_s_q & pwm_d_q;
    assign dvsr      = sel_i ? 32'(DVSR_SLOW) : 32'(DVSR_FAST);
    assign mode_chg  = (sel_i != sel_q);
    assign tick      = (q_q == 32'd0);
    assign per_full  = (per_q == 8'hff);
    assign hi_inc    = (hi_q == 8'hff) ? hi_q : hi_q + 8'd1;
    assign per_inc   = per_full ? per_q : per_q + 8'd1;
    // A tick coinciding with the latching rise belongs to the period just ending.
    assign per_latch = tick ? per_inc : per_q;

    always_comb begin
        q_d       = (mode_chg || (q_q == dvsr)) ? 32'd0 : q_q + 32'd1;
        state_d   = state_q;
        hi_d      = hi_q;
        per_d     = per_q;
        high_d    = high_q;
        period_d  = period_q;
        duty_d    = duty_q;
        servo_d   = servo_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (mode_chg) begin
            state_d = StIdle;
            hi_d    = 8'd0;
            per_d   = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!pwm_s_q) state_d = StWaitRise;
                end
                StWaitRise: begin
                    if (rise) begin
                        hi_d    = 8'd0;
                        per_d   = 8'd0;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (tick && per_full) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                        hi_d      = 8'd0;
                        per_d     = 8'd0;
                    end else begin
                        if (tick) begin
                            hi_d  = hi_inc;
                            per_d = per_inc;
                        end
                        if (fall) state_d = StLow;
                    end
                end
                StLow: begin
                    if (tick && per_full) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                        hi_d      = 8'd0;
                        per_d     = 8'd0;
                    end else if (rise) begin
                        high_d    = hi_q;
                        period_d  = per_latch;
                        duty_d    = hi_q[7] ? 7'h7f : hi_q[6:0];
                        servo_d   = sel_q ? servo_code(hi_q) : 4'd0;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        hi_d      = 8'd0;
                        per_d     = 8'd0;
                        state_d   = StHigh;
                    end else if (tick) begin
                        per_d = per_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= 1'b0;
            pwm_s_q   <= 1'b0;
            pwm_d_q   <= 1'b0;
            sel_q     <= 1'b0;
            q_q       <= 32'd0;
            state_q   <= StIdle;
            hi_q      <= 8'd0;
            per_q     <= 8'd0;
            high_q    <= 8'd0;
            period_q  <= 8'd0;
            duty_q    <= 7'd0;
            servo_q   <= 4'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= pwm_i;
            pwm_s_q   <= sync_q;
            pwm_d_q   <= pwm_s_q;
            sel_q     <= sel_i;
            q_q       <= q_d;
            state_q   <= state_d;
            hi_q      <= hi_d;
            per_q     <= per_d;
            high_q    <= high_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            servo_q   <= servo_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign high_o    = high_q;
    assign period_o  = period_q;
    assign duty_o    = duty_q;
    assign servo_o   = servo_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_pwm_capture_decoder.sv
// Directed bench for pwm_capture_decoder with a 4-clock fast tick and 8-clock slow tick.
module tb_pwm_capture_decoder;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sel_i;
    logic       pwm_i;
    logic [7:0] high_o;
    logic [7:0] period_o;
    logic [6:0] duty_o;
    logic [3:0] servo_o;
    logic       valid_o;
    logic       timeout_o;

    int n_checks  = 0;
    int n_bad     = 0;
    int valid_cnt = 0;
    int v0;

    pwm_capture_decoder #(
        .DVSR_FAST(3),
        .DVSR_SLOW(7)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sel_i    (sel_i),
        .pwm_i    (pwm_i),
        .high_o   (high_o),
        .period_o (period_o),
        .duty_o   (duty_o),
        .servo_o  (servo_o),
        .valid_o  (valid_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) valid_cnt = valid_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int h, input int p, input int d,
                             input int s);
        check_eq({tag, "_high"}, 32'(high_o), 32'(h));
        check_eq({tag, "_period"}, 32'(period_o), 32'(p));
        check_eq({tag, "_duty"}, 32'(duty_o), 32'(d));
        check_eq({tag, "_servo"}, 32'(servo_o), 32'(s));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        sel_i = 1'b0;
        pwm_i = 1'b0;
        wait_clk(3);
        check_out("rst", 0, 0, 0, 0);
        check_eq("rst_valid", 32'(valid_o), 0);
        check_eq("rst_timeout", 32'(timeout_o), 0);
        rst_i = 1'b0;

        // 1: idle low input never times out or strobes
        v0 = valid_cnt;
        wait_clk(2000);
        check_out("idle", 0, 0, 0, 0);
        check_eq("idle_valid", 32'(valid_cnt - v0), 0);
        check_eq("idle_timeout", 32'(timeout_o), 0);

        // 2: fast mode 40/128 ticks
        v0 = valid_cnt;
        pwm_i = 1'b1; wait_clk(160);
        pwm_i = 1'b0; wait_clk(352);
        check_eq("fast_first_none", 32'(valid_cnt - v0), 0);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("fast_first_valid", 32'(valid_cnt - v0), 1);
        check_out("fast1", 40, 128, 40, 0);
        wait_clk(154);
        pwm_i = 1'b0; wait_clk(352);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("fast_second_valid", 32'(valid_cnt - v0), 2);
        wait_clk(154);
        pwm_i = 1'b0; wait_clk(352);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("fast_third_valid", 32'(valid_cnt - v0), 3);
        check_out("fast3", 40, 128, 40, 0);
        pwm_i = 1'b0; wait_clk(20);

        // 3: servo mode, highs of 5, 7, 10 ticks in 128-tick periods
        sel_i = 1'b1; wait_clk(20);
        v0 = valid_cnt;
        pwm_i = 1'b1; wait_clk(40);
        pwm_i = 1'b0; wait_clk(984);
        pwm_i = 1'b1; wait_clk(6);
        check_out("servo5", 5, 128, 5, 0);
        wait_clk(50);
        pwm_i = 1'b0; wait_clk(968);
        pwm_i = 1'b1; wait_clk(6);
        check_out("servo7", 7, 128, 7, 6);
        wait_clk(74);
        pwm_i = 1'b0; wait_clk(944);
        pwm_i = 1'b1; wait_clk(6);
        check_out("servo10", 10, 128, 10, 15);
        check_eq("servo_valid_count", 32'(valid_cnt - v0), 3);
        pwm_i = 1'b0; wait_clk(20);

        // 4: stuck-high input times out, outputs hold, recovery clears the flag
        sel_i = 1'b0; wait_clk(20);
        v0 = valid_cnt;
        pwm_i = 1'b1; wait_clk(1000);
        check_eq("to_early", 32'(timeout_o), 0);
        wait_clk(100);
        check_eq("to_set", 32'(timeout_o), 1);
        check_eq("to_high_hold", 32'(high_o), 10);
        check_eq("to_period_hold", 32'(period_o), 128);
        wait_clk(100);
        pwm_i = 1'b0; wait_clk(40);
        check_eq("to_sticky", 32'(timeout_o), 1);
        pwm_i = 1'b1; wait_clk(80);
        pwm_i = 1'b0; wait_clk(240);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("to_recover_valid", 32'(valid_cnt - v0), 1);
        check_eq("to_cleared", 32'(timeout_o), 0);
        check_out("to_recover", 20, 80, 20, 0);

        // 5: mode switch mid-high discards the period
        wait_clk(20);
        v0 = valid_cnt;
        sel_i = 1'b1; wait_clk(40);
        pwm_i = 1'b0; wait_clk(400);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("sw_no_valid", 32'(valid_cnt - v0), 0);
        wait_clk(90);
        pwm_i = 1'b0; wait_clk(416);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("sw_valid", 32'(valid_cnt - v0), 1);
        check_out("sw", 12, 64, 12, 15);

        // 6: reset mid-low clears outputs at once
        wait_clk(90);
        pwm_i = 1'b0; wait_clk(100);
        rst_i = 1'b1;
        #2;
        check_out("arst", 0, 0, 0, 0);
        check_eq("arst_valid", 32'(valid_o), 0);
        check_eq("arst_timeout", 32'(timeout_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        v0 = valid_cnt;
        wait_clk(40);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("arst_first_none", 32'(valid_cnt - v0), 0);
        wait_clk(58);
        pwm_i = 1'b0; wait_clk(448);
        pwm_i = 1'b1; wait_clk(6);
        check_eq("arst_valid_after", 32'(valid_cnt - v0), 1);
        check_out("arst_meas", 8, 64, 8, 9);
        check_eq("arst_meas_timeout", 32'(timeout_o), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
